// File: rtl/hw_mutex_core_if_if.sv
// rtl/hw_mutex_core_if_if.sv - per-core peripheral bus bundle for the mutex front-end
interface hw_mutex_core_if_if #(
  parameter int NB_CORES    = 8,
  parameter int MUTEX_MSG_W = 32,
  parameter int ADDR_W      = 4
);
  logic [NB_CORES-1:0]                  req;
  logic [NB_CORES-1:0]                  we;
  logic [NB_CORES-1:0][ADDR_W-1:0]      add;
  logic [NB_CORES-1:0][MUTEX_MSG_W-1:0] wdata;
  logic [NB_CORES-1:0]                  gnt;
  logic [NB_CORES-1:0]                  r_valid;
  logic [NB_CORES-1:0][MUTEX_MSG_W-1:0] r_rdata;

  // Cores issue accesses; the front-end grants and responds.
  modport master (output req, we, add, wdata, input gnt, r_valid, r_rdata);
  modport slave  (input req, we, add, wdata, output gnt, r_valid, r_rdata);
endinterface

// File: rtl/hw_mutex_core_if.sv
// rtl/hw_mutex_core_if.sv - per-core lock/unlock decoder and blocking-read front-end for the mutex unit
module hw_mutex_core_if #(
  parameter int NB_CORES    = 8,
  parameter int MUTEX_MSG_W = 32,
  parameter int ADDR_W      = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  hw_mutex_core_if_if.slave      bus,
  output logic [NB_CORES-1:0]    lock_req_o,
  output logic [NB_CORES-1:0]    unlock_req_o,
  output logic [MUTEX_MSG_W-1:0] mutex_msg_wdata_o,
  input  logic [MUTEX_MSG_W-1:0] mutex_msg_rdata_i,
  input  logic [NB_CORES-1:0]    mutex_event_i,
  output logic [NB_CORES-1:0]    core_waiting_o
);

  localparam logic [ADDR_W-1:0] LOCK_OFF   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] UNLOCK_OFF = ADDR_W'(4);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_EVT = 2'd1,
    RSP_LOCK = 2'd2,
    RSP_ACK  = 2'd3
  } state_e;

  state_e state_q [NB_CORES];
  state_e state_d [NB_CORES];

  logic [NB_CORES-1:0]                  gnt;
  logic [NB_CORES-1:0]                  lock_req;
  logic [NB_CORES-1:0]                  unlock_req;
  logic [NB_CORES-1:0]                  r_valid;
  logic [NB_CORES-1:0][MUTEX_MSG_W-1:0] r_rdata;
  logic [NB_CORES-1:0]                  waiting;

  // State register; reset drops any pending lock so no core stays blocked.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NB_CORES; i++) state_q[i] <= IDLE;
    end else begin
      for (int i = 0; i < NB_CORES; i++) state_q[i] <= state_d[i];
    end
  end

  // Per-core next state, access decode and response generation.
  always_comb begin
    gnt        = '0;
    lock_req   = '0;
    unlock_req = '0;
    r_valid    = '0;
    r_rdata    = '0;
    waiting    = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE: begin
          gnt[i] = bus.req[i];
          if (bus.req[i]) begin
            if (!bus.we[i] && bus.add[i] == LOCK_OFF) begin
              lock_req[i] = 1'b1;
              // The mutex may assign ownership in the same cycle as the pulse.
              state_d[i]  = mutex_event_i[i] ? RSP_LOCK : WAIT_EVT;
            end else if (bus.we[i] && bus.add[i] == UNLOCK_OFF) begin
              unlock_req[i] = 1'b1;
              state_d[i]    = RSP_ACK;
            end else begin
              state_d[i] = RSP_ACK;
            end
          end
        end
        WAIT_EVT: begin
          waiting[i] = 1'b1;
          if (mutex_event_i[i]) state_d[i] = RSP_LOCK;
        end
        RSP_LOCK: begin
          // The mutex register already holds the releasing owner's message.
          r_valid[i] = 1'b1;
          r_rdata[i] = mutex_msg_rdata_i;
          state_d[i] = IDLE;
        end
        RSP_ACK: begin
          r_valid[i] = 1'b1;
          state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // Unlock message comes from the lowest-index core unlocking this cycle.
  always_comb begin
    mutex_msg_wdata_o = '0;
    for (int i = NB_CORES - 1; i >= 0; i--) begin
      if (unlock_req_o[i]) mutex_msg_wdata_o = bus.wdata[i];
    end
  end

  // Pulses are masked during reset because a requesting core still sees IDLE.
  assign lock_req_o     = lock_req & {NB_CORES{rst_ni}};
  assign unlock_req_o   = unlock_req & {NB_CORES{rst_ni}};
  assign core_waiting_o = waiting;
  assign bus.gnt        = gnt;
  assign bus.r_valid    = r_valid;
  assign bus.r_rdata    = r_rdata;

`ifndef SYNTHESIS
  for (genvar g = 0; g < NB_CORES; g++) begin : g_evt_chk
    // An event is only meaningful while waiting or alongside this core's lock pulse.
    a_evt_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
      mutex_event_i[g] |-> (state_q[g] == WAIT_EVT || lock_req[g]));
  end
`endif

endmodule
